alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
- Sequential front/back end for the team's 3-bit-control combinational ALU.
- Accepts register-addressed instructions over a valid/ready handshake and reads operands from an internal register file.
- Drives the ALU operand/control inputs, captures out/overflow/zero, and writes the result back to the register file.
- Exposes a one-cycle writeback strobe plus sticky-free status flags. The ALU itself stays outside this block; this block sits directly upstream (operands) and downstream (results) of it.

Parameters:
- N, 4, datapath width; must match the ALU's N.
- REGS, 4, register-file depth (power of 2, ≥2); address width AW = clog2(REGS).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept an instruction
- instr_op  in  3  opcode: ALU control codes 000-110; 111 = LDI (load immediate)
- instr_rd  in  AW  destination register
- instr_rs1  in  AW  source register A
- instr_rs2  in  AW  source register B
- instr_imm  in  N  immediate, used only by LDI
- alu_a  out  N  ALU operand a
- alu_b  out  N  ALU operand b
- alu_control  out  3  ALU control
- alu_out  in  N  ALU result
- alu_overflow  in  1  ALU carry/borrow
- alu_zero  in  1  ALU zero flag
- wb_valid  out  1  one-cycle writeback strobe
- wb_rd  out  AW  writeback register
- wb_data  out  N  writeback value
- flag_zero  out  1  zero flag of last ALU instruction
- flag_ovf  out  1  overflow flag of last ALU instruction
- dbg_addr  in  AW  debug read address
- dbg_data  out  N  combinational rf[dbg_addr]

Behaviour:
- Reset (async, immediate):
  - state=IDLE; all rf entries=0; latched instruction=0; result register=0.
  - flag_zero=0, flag_ovf=0, wb_valid=0, wb_rd=0, wb_data=0.
  - alu_a=0, alu_b=0, alu_control=000; instr_ready=1 once reset deasserts.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready at the edge: latch op/rd/rs1/rs2/imm.
  - Next state is EXEC if op≠111. For LDI (op=111), next state is WB with result=imm.
- EXEC:
  - instr_ready=0.
  - Combinationally drive alu_a=rf[rs1], alu_b=rf[rs2], alu_control=op.
  - At the edge, capture alu_out, alu_overflow, alu_zero into the result register; next state is WB.
- WB:
  - instr_ready=0; wb_valid=1; wb_rd=latched rd; wb_data=result.
  - At the edge: rf[rd]<=result. For ALU ops, flag_zero/flag_ovf<=captured values; LDI leaves flags unchanged. Next state is IDLE.
- Outside EXEC: alu_a=0, alu_b=0, alu_control=000.
- Latency and throughput:
  - ALU op: accept edge to WB cycle is 2 cycles; throughput is 1 instruction per 3 cycles.
  - LDI: 1 cycle to WB; throughput is 1 per 2 cycles.
- Hazards:
  - Operands are read in EXEC, after the previous WB write has completed, so back-to-back dependencies (rd of instr k = rs of instr k+1) always see the new value. No bypass is needed.
  - rd==rs1==rs2 is legal.
- Handshake:
  - Transfer occurs only when valid&&ready.
  - The source must hold the instruction fields stable while valid is high and ready is low.
  - Deasserting valid without a transfer is allowed.
- Arithmetic: results are taken from the ALU verbatim, N-bit wrap included; no width extension inside this block.
- ALU opcode 111 never reaches the ALU; codes 000-110 pass through unchanged.
- dbg_data reflects the rf contents after each edge; in the WB cycle it shows the old value.
- Reset mid-operation (EXEC or WB): the in-flight instruction is discarded, no rf write occurs, and wb_valid drops immediately.

Decomposition:
- Shared package holds:
  - opcode localparams OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_SLT=100, OP_XOR=101, OP_NOR=110, OP_LDI=111;
  - state encoding IDLE/EXEC/WB.
- One natural sub-module, alu_regfile: REGS×N, async-reset, one write port, three combinational read ports (rs1, rs2, dbg).
- The FSM stays in the top.

Test Plan:
- Reset, then dbg_addr sweep 0..3 -> dbg_data=0 everywhere; instr_ready=1; wb_valid=0; flags 0.
- LDI r1=5, LDI r2=3, ADD r3=r1+r2 -> ADD has wb_valid exactly 2 cycles after accept, wb_data=8, flag_ovf=0, flag_zero=0; rf[3]=8.
- LDI r1=9, LDI r2=8, ADD r0=r1+r2 -> wb_data=1, flag_ovf=1. Then SUB r0=r1-r1 -> wb_data=0, flag_zero=1, flag_ovf=0.
- LDI r1=3, LDI r2=5: SUB r3=r1-r2 -> wb_data=14, flag_ovf=1. SLT r0=r1<r2 -> 1. NOR r0=r1 NOR r2 -> 8. An LDI afterwards leaves the flags unchanged.
- instr_valid held high with a stream ADD r1=r1+r1 (r1=1 initially) -> ready low in EXEC/WB, one accept per 3 cycles; successive wb_data are 2, 4, 8, then 0 with ovf=1.
- Assert rst during EXEC of ADD r3 -> wb_valid never pulses, rf[3]=0, state IDLE, instr_ready=1 after release.

Source files
------------

// File: rtl/alu_issue_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_issue_unit_pkg
// Brief  : Opcodes and FSM state encoding shared by the ALU issue unit.
// Rev    : 1.0
// ============================================================================
package alu_issue_unit_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_NOR = 3'b110;
  localparam logic [2:0] OP_LDI = 3'b111;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module : alu_regfile
// Brief  : REGS x N register file, one write port, three async read ports.
// Rev    : 1.0
// ============================================================================
module alu_regfile
  import alu_issue_unit_pkg::*;
#(
  parameter int N    = 4,
  parameter int REGS = 4,
  parameter int AW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [N-1:0]  rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [N-1:0]  rdata_b,
  input  logic [AW-1:0] raddr_dbg,
  output logic [N-1:0]  rdata_dbg
);

  logic [N-1:0] r_mem [REGS];

  generate
    for (genvar i = 0; i < REGS; i++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_mem[i] <= '0;
        end else if (we && (waddr == AW'(i))) begin
          r_mem[i] <= wdata;
        end
      end
    end
  endgenerate

  assign rdata_a   = r_mem[raddr_a];
  assign rdata_b   = r_mem[raddr_b];
  assign rdata_dbg = r_mem[raddr_dbg];

endmodule
`default_nettype wire

// File: rtl/alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module : alu_issue_unit
// Brief  : Issue/writeback sequencer around an external 3-bit-control ALU.
// Rev    : 1.0
// ============================================================================
module alu_issue_unit
  import alu_issue_unit_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int REGS = 4,
  localparam int AW   = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs1,
  input  logic [AW-1:0] instr_rs2,
  input  logic [N-1:0]  instr_imm,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [2:0]    alu_control,
  input  logic [N-1:0]  alu_out,
  input  logic          alu_overflow,
  input  logic          alu_zero,
  output logic          wb_valid,
  output logic [AW-1:0] wb_rd,
  output logic [N-1:0]  wb_data,
  output logic          flag_zero,
  output logic          flag_ovf,
  input  logic [AW-1:0] dbg_addr,
  output logic [N-1:0]  dbg_data
);

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [2:0]    r_op;
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_rs1;
  logic [AW-1:0] r_rs2;
  logic [N-1:0]  r_result;
  logic          r_res_ovf;
  logic          r_res_zero;
  logic          r_flag_zero;
  logic          r_flag_ovf;
  logic          w_accept;
  logic          w_rf_we;
  logic [N-1:0]  w_rs1_data;
  logic [N-1:0]  w_rs2_data;

  assign w_accept = instr_valid && (r_state == IDLE);
  assign w_rf_we  = (r_state == WB);

  alu_regfile #(
    .N    (N),
    .REGS (REGS),
    .AW   (AW)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we        (w_rf_we),
    .waddr     (r_rd),
    .wdata     (r_result),
    .raddr_a   (r_rs1),
    .rdata_a   (w_rs1_data),
    .raddr_b   (r_rs2),
    .rdata_b   (w_rs2_data),
    .raddr_dbg (dbg_addr),
    .rdata_dbg (dbg_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next_state = (instr_op == OP_LDI) ? WB : EXEC;
      EXEC: w_next_state = WB;
      WB:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // LDI bypasses the ALU: the immediate lands straight in the result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op        <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_result    <= '0;
      r_res_ovf   <= 1'b0;
      r_res_zero  <= 1'b0;
      r_flag_zero <= 1'b0;
      r_flag_ovf  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= instr_op;
        r_rd  <= instr_rd;
        r_rs1 <= instr_rs1;
        r_rs2 <= instr_rs2;
        if (instr_op == OP_LDI) begin
          r_result <= instr_imm;
        end
      end
      if (r_state == EXEC) begin
        r_result   <= alu_out;
        r_res_ovf  <= alu_overflow;
        r_res_zero <= alu_zero;
      end
      if ((r_state == WB) && (r_op != OP_LDI)) begin
        r_flag_zero <= r_res_zero;
        r_flag_ovf  <= r_res_ovf;
      end
    end
  end

  always_comb begin
    instr_ready = (r_state == IDLE);
    alu_a       = '0;
    alu_b       = '0;
    alu_control = OP_ADD;
    wb_valid    = 1'b0;
    wb_rd       = '0;
    wb_data     = '0;
    if (r_state == EXEC) begin
      alu_a       = w_rs1_data;
      alu_b       = w_rs2_data;
      alu_control = r_op;
    end
    if (r_state == WB) begin
      wb_valid = 1'b1;
      wb_rd    = r_rd;
      wb_data  = r_result;
    end
  end

  assign flag_zero = r_flag_zero;
  assign flag_ovf  = r_flag_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_issue_unit
// Brief  : Directed vector bench for alu_issue_unit with a behavioural ALU.
// Rev    : 1.0
// ============================================================================
module tb_alu_issue_unit;
  import alu_issue_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [1:0] instr_rd, instr_rs1, instr_rs2;
  logic [3:0] instr_imm;
  logic [3:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_control;
  logic       alu_overflow, alu_zero;
  logic       wb_valid;
  logic [1:0] wb_rd;
  logic [3:0] wb_data;
  logic       flag_zero, flag_ovf;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_unit #(.N(4), .REGS(4)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_zero(flag_zero), .flag_ovf(flag_ovf),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Stand-in for the external ALU: carry/borrow on ADD/SUB, unsigned SLT.
  logic [4:0] alu_wide;
  always_comb begin
    alu_wide = 5'd0;
    case (alu_control)
      OP_ADD:  alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB:  alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
      OP_AND:  alu_wide = {1'b0, alu_a & alu_b};
      OP_OR:   alu_wide = {1'b0, alu_a | alu_b};
      OP_SLT:  alu_wide = (alu_a < alu_b) ? 5'd1 : 5'd0;
      OP_XOR:  alu_wide = {1'b0, alu_a ^ alu_b};
      OP_NOR:  alu_wide = {1'b0, ~(alu_a | alu_b)};
      default: alu_wide = 5'd0;
    endcase
    alu_out      = alu_wide[3:0];
    alu_overflow = ((alu_control == OP_ADD) || (alu_control == OP_SUB)) ? alu_wide[4] : 1'b0;
    alu_zero     = (alu_wide[3:0] == 4'd0);
  end

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd, rs1, rs2;
    logic [3:0] imm;
    logic [3:0] exp_data;
    int         exp_lat;
    logic       exp_zero, exp_ovf;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns writeback info and the flags one cycle later.
  task automatic run_instr(input logic [2:0] op, input logic [1:0] rd, rs1, rs2,
                           input logic [3:0] imm, output logic [3:0] data,
                           output logic [1:0] wrd, output int lat,
                           output logic fz, output logic fo);
    int guard = 0;
    instr_valid = 1'b1; instr_op = op; instr_rd = rd;
    instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    while (!instr_ready && guard < 10) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    lat = 1;
    while (!wb_valid && lat < 6) begin @(negedge clk); lat++; end
    data = wb_data;
    wrd  = wb_rd;
    @(negedge clk);
    fz = flag_zero;
    fo = flag_ovf;
  endtask

  initial begin
    logic [3:0] d;
    logic [1:0] r;
    int         lat;
    logic       fz, fo;
    logic [3:0] exp_s[4];

    vecs[0]  = '{OP_LDI, 2'd1, 2'd0, 2'd0, 4'd5, 4'd5,  1, 1'b0, 1'b0};
    vecs[1]  = '{OP_LDI, 2'd2, 2'd0, 2'd0, 4'd3, 4'd3,  1, 1'b0, 1'b0};
    vecs[2]  = '{OP_ADD, 2'd3, 2'd1, 2'd2, 4'd0, 4'd8,  2, 1'b0, 1'b0};
    vecs[3]  = '{OP_LDI, 2'd1, 2'd0, 2'd0, 4'd9, 4'd9,  1, 1'b0, 1'b0};
    vecs[4]  = '{OP_LDI, 2'd2, 2'd0, 2'd0, 4'd8, 4'd8,  1, 1'b0, 1'b0};
    vecs[5]  = '{OP_ADD, 2'd0, 2'd1, 2'd2, 4'd0, 4'd1,  2, 1'b0, 1'b1};
    vecs[6]  = '{OP_SUB, 2'd0, 2'd1, 2'd1, 4'd0, 4'd0,  2, 1'b1, 1'b0};
    vecs[7]  = '{OP_LDI, 2'd1, 2'd0, 2'd0, 4'd3, 4'd3,  1, 1'b1, 1'b0};
    vecs[8]  = '{OP_LDI, 2'd2, 2'd0, 2'd0, 4'd5, 4'd5,  1, 1'b1, 1'b0};
    vecs[9]  = '{OP_SUB, 2'd3, 2'd1, 2'd2, 4'd0, 4'd14, 2, 1'b0, 1'b1};
    vecs[10] = '{OP_SLT, 2'd0, 2'd1, 2'd2, 4'd0, 4'd1,  2, 1'b0, 1'b0};
    vecs[11] = '{OP_NOR, 2'd0, 2'd1, 2'd2, 4'd0, 4'd8,  2, 1'b0, 1'b0};
    vecs[12] = '{OP_ADD, 2'd0, 2'd3, 2'd3, 4'd0, 4'd12, 2, 1'b0, 1'b1};
    vecs[13] = '{OP_LDI, 2'd1, 2'd0, 2'd0, 4'd0, 4'd0,  1, 1'b0, 1'b1};
    vecs[14] = '{OP_AND, 2'd0, 2'd3, 2'd2, 4'd0, 4'd4,  2, 1'b0, 1'b0};
    vecs[15] = '{OP_OR,  2'd0, 2'd1, 2'd2, 4'd0, 4'd5,  2, 1'b0, 1'b0};
    vecs[16] = '{OP_XOR, 2'd0, 2'd3, 2'd2, 4'd0, 4'd11, 2, 1'b0, 1'b0};

    rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0;
    instr_rs1 = '0; instr_rs2 = '0; instr_imm = '0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int a = 0; a < 4; a++) begin
      dbg_addr = 2'(a);
      #1 check($sformatf("reset_rf%0d", a), dbg_data, 0);
    end
    check("reset_ready", instr_ready, 1);
    check("reset_wb_valid", wb_valid, 0);
    check("reset_wb_data", wb_data, 0);
    check("reset_flag_zero", flag_zero, 0);
    check("reset_flag_ovf", flag_ovf, 0);
    check("reset_alu_ctl", {alu_a, alu_b, 1'b0, alu_control}, 0);
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      run_instr(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, d, r, lat, fz, fo);
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_data", i), d, vecs[i].exp_data);
      check($sformatf("v%0d_rd", i), r, vecs[i].rd);
      check($sformatf("v%0d_zero", i), fz, vecs[i].exp_zero);
      check($sformatf("v%0d_ovf", i), fo, vecs[i].exp_ovf);
      dbg_addr = vecs[i].rd;
      #1 check($sformatf("v%0d_rf", i), dbg_data, vecs[i].exp_data);
      if (i == 2) begin
        dbg_addr = 2'd3;
        #1 check("rf3_after_add", dbg_data, 8);
      end
    end

    // Held-valid stream of ADD r1=r1+r1: one accept every three cycles.
    run_instr(OP_LDI, 2'd1, 2'd0, 2'd0, 4'd1, d, r, lat, fz, fo);
    exp_s = '{4'd2, 4'd4, 4'd8, 4'd0};
    begin
      int nwb  = 0;
      int cyc  = 0;
      int last = -1;
      instr_valid = 1'b1; instr_op = OP_ADD;
      instr_rd = 2'd1; instr_rs1 = 2'd1; instr_rs2 = 2'd1;
      while (nwb < 4 && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (wb_valid) begin
          check($sformatf("stream%0d_data", nwb), wb_data, exp_s[nwb]);
          check($sformatf("stream%0d_ready", nwb), instr_ready, 0);
          if (last >= 0) check($sformatf("stream%0d_gap", nwb), cyc - last, 3);
          last = cyc;
          nwb++;
          if (nwb == 4) instr_valid = 1'b0;
        end else if (cyc > 1 && (cyc - last) == 2 && last >= 0) begin
          check($sformatf("stream%0d_exec_ready", nwb), instr_ready, 0);
        end
      end
      check("stream_count", nwb, 4);
      @(negedge clk);
      check("stream_ovf", flag_ovf, 1);
      check("stream_zero", flag_zero, 1);
    end

    // Reset asserted while an ADD r3 is in EXEC.
    run_instr(OP_LDI, 2'd1, 2'd0, 2'd0, 4'd2, d, r, lat, fz, fo);
    run_instr(OP_LDI, 2'd2, 2'd0, 2'd0, 4'd3, d, r, lat, fz, fo);
    instr_valid = 1'b1; instr_op = OP_ADD;
    instr_rd = 2'd3; instr_rs1 = 2'd1; instr_rs2 = 2'd2;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    check("exec_alu_a", alu_a, 2);
    check("exec_alu_b", alu_b, 3);
    check("exec_alu_ctl", alu_control, OP_ADD);
    rst = 1'b1;
    #1;
    check("midrst_wb_valid", wb_valid, 0);
    check("midrst_alu_a", alu_a, 0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int pulses = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (wb_valid) pulses++;
      end
      check("midrst_no_wb", pulses, 0);
    end
    check("midrst_ready", instr_ready, 1);
    dbg_addr = 2'd3;
    #1 check("midrst_rf3", dbg_data, 0);
    dbg_addr = 2'd1;
    #1 check("midrst_rf1", dbg_data, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
